mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter for the core's single memory port. It shares the port between the instruction-fetch path (ifu) and the load/store path (lsu), with one transaction outstanding at a time. Requests use a valid/ready handshake, and each response is routed back to its owner. A pipeline flush (jump/hold redirect) causes the arbiter to drop a stale in-flight fetch response.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive IFU losses before IFU is forced to win (1..15)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch address (pc)
- if_rsp_valid  out  1  one-cycle pulse, fetch data valid
- if_rsp_data  out  DATA_W  fetched instruction
- flush_i  in  1  redirect; discard fetch in flight
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_addr  in  ADDR_W  data address
- ls_we  in  1  1 = store
- ls_wdata  in  DATA_W  store data
- ls_wstrb  in  DATA_W/8  byte enables
- ls_rsp_valid  out  1  one-cycle pulse, load data / store ack
- ls_rsp_data  out  DATA_W  load data (mem_rsp_data for stores)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_we, mem_wdata, mem_wstrb  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_rsp_valid  in  1  memory response
- mem_rsp_data  in  DATA_W  response data
- owner_o  out  2  01 = IFU, 10 = LSU, 00 = idle

## Operation
- States: IDLE, REQ, RSP.
- IDLE, arbitration (combinational ready):
  - flush_i=1 masks if_req_valid.
  - Only one master valid → that master is granted.
  - Both valid → LSU is granted, unless starve_cnt==STARVE_MAX, in which case IFU is granted.
  - The granted master's req_ready=1.
  - On handshake: latch addr/we/wdata/wstrb (IFU: we=0, wstrb=0), set owner, go to REQ.
  - Both req_ready outputs are 0 in every state other than IDLE.
- starve_cnt: 4-bit, saturating at STARVE_MAX.
  - Increments when IFU is valid and LSU is granted.
  - Clears when IFU is granted.
- REQ: mem_req_valid=1 with stable fields until mem_req_ready=1, then go to RSP. mem_req_valid is never withdrawn once raised, flush included.
- RSP: wait for mem_rsp_valid.
  - On the response, register mem_rsp_data into the owner's rsp_data and pulse that owner's rsp_valid on the next cycle.
  - Clear owner and go to IDLE.
  - mem_rsp_valid outside RSP is ignored.
- Drop flag:
  - Set when flush_i=1 while owner=IFU in REQ or RSP, including the same cycle as mem_rsp_valid.
  - When set, the IFU response is consumed without pulsing if_rsp_valid.
  - Cleared on return to IDLE.
- LSU transactions are unaffected by flush_i.
- rsp_data holds its last value between pulses.

## Timing
- Reset values: state IDLE, owner_o 0, all valid/ready outputs 0, all data/address outputs 0, starve_cnt 0, drop 0.
- Assertion of rst_n mid-transaction aborts the transaction immediately; no response is delivered after reset.
- Minimum transaction, request handshake at edge 0:
  - mem_req_valid high in cycle 1.
  - mem_req_ready in cycle 1 → RSP in cycle 2.
  - mem_rsp_valid in cycle 2 → rsp_valid pulse in cycle 3, IDLE in cycle 3.
  - Next handshake can occur in cycle 3 (back-to-back spacing of 3 cycles).
- Memory responds no earlier than the cycle after mem_req_ready.
- Each memory stall cycle (req or rsp) adds exactly one cycle of latency.
- flush_i and if_req_valid in the same IDLE cycle: IFU is not granted; LSU can be granted that cycle.

## Test plan
- **Single fetch:** if_addr=0x100, memory ready immediately, rsp 0x00000013 → if_rsp_valid pulses in cycle 3 with 0x00000013; owner_o goes 01→00.
- **Contention:** both valid continuously, STARVE_MAX=4 → grants L,L,L,L,I,L,L,L,L,I…; starve_cnt never exceeds 4.
- **Store with stalls:** ls_we=1, addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF; mem_req_ready low for 3 cycles → fields stay stable while stalled; exactly one ls_rsp_valid pulse after the ack.
- **Flush in RSP:**
  - flush_i pulses while an IFU fetch is waiting on a response → no if_rsp_valid.
  - The next IFU request is accepted in the cycle after the dropped response.
  - Repeat with flush_i coincident with mem_rsp_valid → response still dropped.
- **Flush in IDLE:** flush_i together with if_req_valid and ls_req_valid → ls_req_ready=1, if_req_ready=0.
- **Reset mid-transaction:** assert rst_n low during REQ and during RSP → all outputs return to reset values at once; a late mem_rsp_valid produces no rsp pulse.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: IFU/LSU request-response and memory-port signals shared by the arbiter
// Ports: slave = arbiter view (takes fetch/load-store requests, drives the memory port),
//        master = environment view (cores and memory model).
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              flush_i;
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_we;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W/8-1:0] ls_wstrb;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic [1:0]        owner_o;
  modport slave (
    input  if_req_valid, if_addr, flush_i, ls_req_valid, ls_addr, ls_we, ls_wdata, ls_wstrb,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid, ls_rsp_data,
           mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb, owner_o
  );
  modport master (
    output if_req_valid, if_addr, flush_i, ls_req_valid, ls_addr, ls_we, ls_wdata, ls_wstrb,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid, ls_rsp_data,
           mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb, owner_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch (IFU) and load/store (LSU), one transaction at a time
// Ports: clk, rst_n (async, active-low), bus (mem_bus_arbiter_if.slave: both master
//        request/response channels, flush_i, the memory request/response port, owner_o).
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_bus_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  localparam logic [1:0] OWN_IF = 2'b01;
  localparam logic [1:0] OWN_LS = 2'b10;
  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [3:0]          starve_q, starve_d;
  logic                drop_q, drop_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                if_rsp_valid_q, if_rsp_valid_d, ls_rsp_valid_q, ls_rsp_valid_d;
  logic [DATA_W-1:0]   if_rsp_data_q, if_rsp_data_d, ls_rsp_data_q, ls_rsp_data_d;
  logic                if_v, starved, gnt_if, gnt_ls, rsp_fire;
  // A flushed fetch request is treated as absent for arbitration and starvation.
  assign if_v     = bus.if_req_valid & ~bus.flush_i;
  assign starved  = starve_q == 4'(STARVE_MAX);
  assign gnt_if   = state_q == IDLE & if_v & (~bus.ls_req_valid | starved);
  assign gnt_ls   = state_q == IDLE & bus.ls_req_valid & ~gnt_if;
  assign rsp_fire = state_q == RSP & bus.mem_rsp_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = (gnt_if | gnt_ls)                   ? REQ  :
              (state_q == REQ & bus.mem_req_ready) ? RSP  :
              rsp_fire                             ? IDLE : state_q;
  end
  always_comb begin
    bus.if_req_ready  = gnt_if;
    bus.ls_req_ready  = gnt_ls;
    bus.mem_req_valid = state_q == REQ;
  end
  always_comb begin
    owner_d        = gnt_if ? OWN_IF : gnt_ls ? OWN_LS : rsp_fire ? 2'b00 : owner_q;
    starve_d       = gnt_if ? 4'd0 : (gnt_ls & if_v & ~starved) ? starve_q + 4'd1 : starve_q;
    // Sticky across REQ/RSP so a flush coincident with the response still drops it.
    drop_d         = state_d == IDLE ? 1'b0 : drop_q | (bus.flush_i & owner_q == OWN_IF);
    addr_d         = gnt_if ? bus.if_addr : gnt_ls ? bus.ls_addr : addr_q;
    we_d           = gnt_ls ? bus.ls_we : gnt_if ? 1'b0 : we_q;
    wdata_d        = gnt_ls ? bus.ls_wdata : gnt_if ? '0 : wdata_q;
    wstrb_d        = gnt_ls ? bus.ls_wstrb : gnt_if ? '0 : wstrb_q;
    if_rsp_valid_d = rsp_fire & owner_q == OWN_IF & ~drop_q & ~bus.flush_i;
    ls_rsp_valid_d = rsp_fire & owner_q == OWN_LS;
    if_rsp_data_d  = if_rsp_valid_d ? bus.mem_rsp_data : if_rsp_data_q;
    ls_rsp_data_d  = ls_rsp_valid_d ? bus.mem_rsp_data : ls_rsp_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q        <= '0;
      starve_q       <= '0;
      drop_q         <= 1'b0;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      ls_rsp_data_q  <= '0;
    end else begin
      owner_q        <= owner_d;
      starve_q       <= starve_d;
      drop_q         <= drop_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      ls_rsp_data_q  <= ls_rsp_data_d;
    end
  end
  assign bus.mem_addr     = addr_q;
  assign bus.mem_we       = we_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_wstrb    = wstrb_q;
  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.ls_rsp_valid = ls_rsp_valid_q;
  assign bus.ls_rsp_data  = ls_rsp_data_q;
  assign bus.owner_o      = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, directed corner sequences and a randomized run against a transaction-level model
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  typedef struct {
    logic ifv;
    logic lsv;
    logic fl;
    logic e_if;
    logic e_ls;
  } vec_t;
  vec_t tbl [8] = '{
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
    '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
    '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1}
  };
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.flush_i = 1'b0;
    bus.ls_req_valid = 1'b0; bus.ls_addr = '0; bus.ls_we = 1'b0;
    bus.ls_wdata = '0; bus.ls_wstrb = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    idle_in;
    tick;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic chk_rst_outs(input string t);
    chk({t, "_if_rdy"}, 32'(bus.if_req_ready), 0);
    chk({t, "_ls_rdy"}, 32'(bus.ls_req_ready), 0);
    chk({t, "_if_rv"}, 32'(bus.if_rsp_valid), 0);
    chk({t, "_ls_rv"}, 32'(bus.ls_rsp_valid), 0);
    chk({t, "_if_rd"}, bus.if_rsp_data, 0);
    chk({t, "_ls_rd"}, bus.ls_rsp_data, 0);
    chk({t, "_mreqv"}, 32'(bus.mem_req_valid), 0);
    chk({t, "_maddr"}, bus.mem_addr, 0);
    chk({t, "_mwe"}, 32'(bus.mem_we), 0);
    chk({t, "_mwdata"}, bus.mem_wdata, 0);
    chk({t, "_mwstrb"}, 32'(bus.mem_wstrb), 0);
    chk({t, "_owner"}, 32'(bus.owner_o), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    idle_in;
    do_reset;
    #2;
    chk_rst_outs("reset");
    // idle arbitration table from starve 0; valids drop before the edge so no grant occurs
    foreach (tbl[i]) begin
      tick;
      bus.if_req_valid = tbl[i].ifv; bus.ls_req_valid = tbl[i].lsv; bus.flush_i = tbl[i].fl;
      #2;
      chk($sformatf("tbl%0d_if_rdy", i), 32'(bus.if_req_ready), 32'(tbl[i].e_if));
      chk($sformatf("tbl%0d_ls_rdy", i), 32'(bus.ls_req_ready), 32'(tbl[i].e_ls));
      chk($sformatf("tbl%0d_mreqv", i), 32'(bus.mem_req_valid), 0);
      idle_in;
    end
    // single fetch
    do_reset;
    tick; bus.if_req_valid = 1'b1; bus.if_addr = 32'h100; #2;
    chk("sf_rdy", 32'(bus.if_req_ready), 1);
    tick; bus.if_req_valid = 1'b0; bus.mem_req_ready = 1'b1; #2;
    chk("sf_c1_mreqv", 32'(bus.mem_req_valid), 1);
    chk("sf_c1_addr", bus.mem_addr, 32'h100);
    chk("sf_c1_we", 32'(bus.mem_we), 0);
    chk("sf_c1_wstrb", 32'(bus.mem_wstrb), 0);
    chk("sf_c1_owner", 32'(bus.owner_o), 1);
    chk("sf_c1_rdy", 32'(bus.if_req_ready), 0);
    tick; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h13; #2;
    chk("sf_c2_mreqv", 32'(bus.mem_req_valid), 0);
    chk("sf_c2_owner", 32'(bus.owner_o), 1);
    chk("sf_c2_rv", 32'(bus.if_rsp_valid), 0);
    tick; bus.mem_rsp_valid = 1'b0; #2;
    chk("sf_c3_rv", 32'(bus.if_rsp_valid), 1);
    chk("sf_c3_rd", bus.if_rsp_data, 32'h13);
    chk("sf_c3_owner", 32'(bus.owner_o), 0);
    chk("sf_c3_lsrv", 32'(bus.ls_rsp_valid), 0);
    tick; #2;
    chk("sf_c4_rv", 32'(bus.if_rsp_valid), 0);
    chk("sf_c4_hold", bus.if_rsp_data, 32'h13);
    // contention: both masters always valid, memory always ready and responding
    begin
      string exp_s = "LLLLILLLLI";
      byte got [10];
      int n = 0;
      do_reset;
      for (int c = 0; c < 60 && n < 10; c++) begin
        tick;
        bus.if_req_valid = 1'b1; bus.ls_req_valid = 1'b1;
        bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b1;
        #2;
        if (bus.if_req_ready) begin got[n] = "I"; n++; end
        else if (bus.ls_req_ready) begin got[n] = "L"; n++; end
      end
      idle_in;
      chk("contend_cnt", n, 10);
      for (int i = 0; i < n; i++) chk($sformatf("contend_gnt%0d", i), 32'(got[i]), 32'(exp_s[i]));
    end
    // store with request stalls
    begin
      int p = 0;
      int q = 0;
      do_reset;
      tick;
      bus.ls_req_valid = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h2000;
      bus.ls_wdata = 32'hDEADBEEF; bus.ls_wstrb = 4'hF;
      #2;
      chk("st_rdy", 32'(bus.ls_req_ready), 1);
      for (int k = 0; k < 3; k++) begin
        tick;
        bus.ls_req_valid = 1'b0; bus.ls_addr = 32'h5555; bus.ls_wdata = '0; bus.ls_wstrb = '0; bus.ls_we = 1'b0;
        #2;
        chk($sformatf("st_stall%0d_v", k), 32'(bus.mem_req_valid), 1);
        chk($sformatf("st_stall%0d_a", k), bus.mem_addr, 32'h2000);
        chk($sformatf("st_stall%0d_we", k), 32'(bus.mem_we), 1);
        chk($sformatf("st_stall%0d_d", k), bus.mem_wdata, 32'hDEADBEEF);
        chk($sformatf("st_stall%0d_s", k), 32'(bus.mem_wstrb), 32'hF);
        chk($sformatf("st_stall%0d_o", k), 32'(bus.owner_o), 2);
      end
      tick; bus.mem_req_ready = 1'b1; #2;
      chk("st_acc_v", 32'(bus.mem_req_valid), 1);
      tick; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h600D; #2;
      for (int k = 0; k < 5; k++) begin
        tick; bus.mem_rsp_valid = 1'b0; #2;
        p += int'(bus.ls_rsp_valid);
        q += int'(bus.if_rsp_valid);
      end
      chk("st_pulses", p, 1);
      chk("st_if_pulses", q, 0);
      chk("st_rd", bus.ls_rsp_data, 32'h600D);
    end
    // flush while waiting in RSP, then flush coincident with the response
    do_reset;
    tick; bus.if_req_valid = 1'b1; bus.if_addr = 32'h200; #2;
    chk("fl_rdy", 32'(bus.if_req_ready), 1);
    tick; bus.if_req_valid = 1'b0; bus.mem_req_ready = 1'b1; #2;
    tick; bus.mem_req_ready = 1'b0; bus.flush_i = 1'b1; #2;
    chk("fl_owner", 32'(bus.owner_o), 1);
    tick; bus.flush_i = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hBAD; #2;
    tick; bus.mem_rsp_valid = 1'b0; bus.if_req_valid = 1'b1; bus.if_addr = 32'h204; #2;
    chk("fl1_pulse", 32'(bus.if_rsp_valid), 0);
    chk("fl1_next_acc", 32'(bus.if_req_ready), 1);
    tick; bus.if_req_valid = 1'b0; bus.mem_req_ready = 1'b1; #2;
    chk("fl2_addr", bus.mem_addr, 32'h204);
    tick; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.flush_i = 1'b1; bus.mem_rsp_data = 32'hBAD2; #2;
    tick; bus.mem_rsp_valid = 1'b0; bus.flush_i = 1'b0; #2;
    chk("fl2_pulse", 32'(bus.if_rsp_valid), 0);
    chk("fl2_owner", 32'(bus.owner_o), 0);
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h208; #1;
    chk("fl3_rdy", 32'(bus.if_req_ready), 1);
    tick; bus.if_req_valid = 1'b0; bus.mem_req_ready = 1'b1; #2;
    tick; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h77; #2;
    tick; bus.mem_rsp_valid = 1'b0; #2;
    chk("fl3_pulse", 32'(bus.if_rsp_valid), 1);
    chk("fl3_rd", bus.if_rsp_data, 32'h77);
    // reset during REQ
    do_reset;
    tick; bus.ls_req_valid = 1'b1; bus.ls_addr = 32'h300; bus.ls_wdata = 32'h1234; bus.ls_wstrb = 4'h3; bus.ls_we = 1'b1; #2;
    tick; idle_in; #2;
    chk("rq_mreqv", 32'(bus.mem_req_valid), 1);
    rst_n = 1'b0; #1;
    chk_rst_outs("rst_req");
    tick; rst_n = 1'b1; bus.mem_rsp_valid = 1'b1; #2;
    tick; #2;
    chk("rq_late_ls", 32'(bus.ls_rsp_valid), 0);
    chk("rq_late_mreqv", 32'(bus.mem_req_valid), 0);
    tick; bus.mem_rsp_valid = 1'b0; #2;
    chk("rq_late_ls2", 32'(bus.ls_rsp_valid), 0);
    // reset during RSP
    do_reset;
    tick; bus.if_req_valid = 1'b1; bus.if_addr = 32'h400; #2;
    tick; bus.if_req_valid = 1'b0; bus.mem_req_ready = 1'b1; #2;
    tick; bus.mem_req_ready = 1'b0; #2;
    chk("rr_owner", 32'(bus.owner_o), 1);
    rst_n = 1'b0; #1;
    chk_rst_outs("rst_rsp");
    tick; rst_n = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h99; #2;
    tick; bus.mem_rsp_valid = 1'b0; #2;
    chk("rr_late_if", 32'(bus.if_rsp_valid), 0);
    tick; #2;
    chk("rr_late_if2", 32'(bus.if_rsp_valid), 0);
    chk("rr_late_owner", 32'(bus.owner_o), 0);
    // randomized run against a transaction-level model
    begin
      int ph = 0;
      int who = 0;
      int starve = 0;
      int wait_n = 0;
      bit drop = 0;
      bit e_ifp = 0;
      bit e_lsp = 0;
      logic [31:0] e_ifd = '0, e_lsd = '0, t_addr = '0, t_wdata = '0;
      logic t_we = 1'b0;
      logic [3:0] t_wstrb = '0;
      bit ifv, eg_if, eg_ls;
      do_reset;
      for (int c = 0; c < 3000; c++) begin
        tick;
        bus.if_req_valid = 1'($urandom_range(0, 1));
        bus.ls_req_valid = 1'($urandom_range(0, 1));
        bus.flush_i = $urandom_range(0, 7) == 0;
        bus.if_addr = $urandom; bus.ls_addr = $urandom; bus.ls_we = 1'($urandom_range(0, 1));
        bus.ls_wdata = $urandom; bus.ls_wstrb = 4'($urandom_range(0, 15));
        bus.mem_req_ready = ph == 1 ? $urandom_range(0, 2) != 0 : 1'($urandom_range(0, 1));
        bus.mem_rsp_valid = ph == 2 ? wait_n == 0 : $urandom_range(0, 3) == 0;
        bus.mem_rsp_data = $urandom;
        #2;
        ifv = bus.if_req_valid && !bus.flush_i;
        eg_if = ph == 0 && ifv && (!bus.ls_req_valid || starve == 4);
        eg_ls = ph == 0 && bus.ls_req_valid && !eg_if;
        chk("rnd_if_rdy", 32'(bus.if_req_ready), 32'(eg_if));
        chk("rnd_ls_rdy", 32'(bus.ls_req_ready), 32'(eg_ls));
        chk("rnd_mreqv", 32'(bus.mem_req_valid), 32'(ph == 1));
        chk("rnd_owner", 32'(bus.owner_o), ph == 0 ? 0 : who);
        chk("rnd_if_rv", 32'(bus.if_rsp_valid), 32'(e_ifp));
        chk("rnd_ls_rv", 32'(bus.ls_rsp_valid), 32'(e_lsp));
        if (e_ifp) chk("rnd_if_rd", bus.if_rsp_data, e_ifd);
        if (e_lsp) chk("rnd_ls_rd", bus.ls_rsp_data, e_lsd);
        if (ph == 1) begin
          chk("rnd_maddr", bus.mem_addr, t_addr);
          chk("rnd_mwe", 32'(bus.mem_we), 32'(t_we));
          chk("rnd_mwstrb", 32'(bus.mem_wstrb), 32'(t_wstrb));
          if (who == 2) chk("rnd_mwdata", bus.mem_wdata, t_wdata);
        end
        e_ifp = 0;
        e_lsp = 0;
        if (ph == 0) begin
          if (eg_if) begin
            who = 1; t_addr = bus.if_addr; t_we = 1'b0; t_wstrb = '0; drop = 0; ph = 1; starve = 0;
          end else if (eg_ls) begin
            who = 2; t_addr = bus.ls_addr; t_we = bus.ls_we; t_wdata = bus.ls_wdata;
            t_wstrb = bus.ls_wstrb; drop = 0; ph = 1;
            if (ifv && starve < 4) starve++;
          end
        end else if (ph == 1) begin
          if (bus.flush_i && who == 1) drop = 1;
          if (bus.mem_req_ready) begin ph = 2; wait_n = $urandom_range(0, 3); end
        end else begin
          if (bus.flush_i && who == 1) drop = 1;
          if (bus.mem_rsp_valid) begin
            if (who == 1 && !drop) begin e_ifp = 1; e_ifd = bus.mem_rsp_data; end
            if (who == 2) begin e_lsp = 1; e_lsd = bus.mem_rsp_data; end
            ph = 0;
          end else wait_n--;
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
